// File: rtl/uart_rx_param_if.sv
// Bus-side bundle between the UART controller and the parametrised receiver.
interface uart_rx_param_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int COMP_W     = 16
);
  logic                          rec_en;
  logic [COMP_W-1:0]             comp;
  logic [1:0]                    data_bits;
  logic                          par_en;
  logic                          par_odd;
  logic                          stop2;
  logic [7:0]                    rx_data;
  logic                          rx_perr;
  logic                          rx_ferr;
  logic                          rx_valid;
  logic                          rx_pop;
  logic [$clog2(FIFO_DEPTH):0]   rx_count;
  logic                          rx_ovf;
  logic                          ovf_clr;

  modport master (
    output rec_en, comp, data_bits, par_en, par_odd, stop2, rx_pop, ovf_clr,
    input  rx_data, rx_perr, rx_ferr, rx_valid, rx_count, rx_ovf
  );

  modport slave (
    input  rec_en, comp, data_bits, par_en, par_odd, stop2, rx_pop, ovf_clr,
    output rx_data, rx_perr, rx_ferr, rx_valid, rx_count, rx_ovf
  );
endinterface

// File: rtl/uart_rx_param.sv
// UART receiver with runtime frame format, glitch-rejecting start detect and RX FIFO.
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | start bit; high at its sample point aborts the frame
// DATA   | shifting data bits LSB first
// PARITY | parity bit check
// STOP   | stop bit(s); push at the last stop-bit sample point
module uart_rx_param #(
  parameter int FIFO_DEPTH = 8,
  parameter int COMP_W     = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           uart_rx,
  uart_rx_param_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic              sync1, rx_s, rx_q;
  logic [COMP_W-1:0] cnt, comp_r;
  logic [1:0]        db_r;
  logic              pe_r, po_r, st2_r, stop_idx;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              perr_r, ferr_r;

  logic start_edge, at_samp, at_wrap, last_data, push;
  assign start_edge = rx_q & ~rx_s;
  assign at_samp    = (cnt == (comp_r >> 1));
  assign at_wrap    = (cnt == comp_r);
  assign last_data  = (bit_idx == (3'd4 + {1'b0, db_r}));
  assign push       = (state == STOP) && at_samp && (stop_idx == st2_r);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
      rx_q  <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      comp_r   <= '0;
      db_r     <= '0;
      pe_r     <= 1'b0;
      po_r     <= 1'b0;
      st2_r    <= 1'b0;
      stop_idx <= 1'b0;
      bit_idx  <= '0;
      shreg    <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
    end else if (!bus.rec_en) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      if (state != IDLE) cnt <= at_wrap ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (start_edge) begin
          state    <= START;
          cnt      <= '0;
          comp_r   <= bus.comp;
          db_r     <= bus.data_bits;
          pe_r     <= bus.par_en;
          po_r     <= bus.par_odd;
          st2_r    <= bus.stop2;
          stop_idx <= 1'b0;
          bit_idx  <= '0;
          shreg    <= '0;
          perr_r   <= 1'b0;
          ferr_r   <= 1'b0;
        end
        START: begin
          if (at_samp && rx_s) state <= IDLE;
          else if (at_wrap)    state <= DATA;
        end
        DATA: begin
          if (at_samp) shreg[bit_idx] <= rx_s;
          if (at_wrap) begin
            if (last_data) state <= pe_r ? PARITY : STOP;
            else           bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          if (at_samp) perr_r <= ((^shreg) ^ rx_s) != po_r;
          if (at_wrap) state <= STOP;
        end
        STOP: begin
          if (at_samp && !rx_s) ferr_r <= 1'b1;
          if (push)         state <= IDLE;
          else if (at_wrap) stop_idx <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry layout: {data[7:0], perr, ferr}
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          do_pop, do_push, ovf_set;

  assign do_pop  = bus.rx_pop && (count != '0);
  assign do_push = push && ((count != FULL_C) || do_pop);
  assign ovf_set = push && (count == FULL_C) && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {shreg, perr_r, ferr_r | ~rx_s};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)          ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
    end
  end

  logic [9:0] head;
  assign head         = mem[rptr];
  assign bus.rx_valid = (count != '0);
  assign bus.rx_data  = bus.rx_valid ? head[9:2] : 8'h00;
  assign bus.rx_perr  = bus.rx_valid & head[1];
  assign bus.rx_ferr  = bus.rx_valid & head[0];
  assign bus.rx_count = count;
  assign bus.rx_ovf   = ovf;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed + randomized bench for uart_rx_param against a frame-level FIFO model.
module tb_uart_rx_param;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  logic clk = 1'b0;
  logic rstn;
  logic uart_rx;
  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  logic ovf_m = 1'b0;

  uart_rx_param_if #(.FIFO_DEPTH(DEPTH), .COMP_W(CW)) bus ();
  uart_rx_param #(.FIFO_DEPTH(DEPTH), .COMP_W(CW)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int comp, input int db, input bit pe, input bit po, input bit s2);
    bus.comp      = CW'(comp);
    bus.data_bits = 2'(db);
    bus.par_en    = pe;
    bus.par_odd   = po;
    bus.stop2     = s2;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (int'(bus.comp) + 1) @(negedge clk);
  endtask

  // bs[0]/bs[1] force the first/second stop bit low
  task automatic send_frame(input logic [7:0] d, input bit flip, input logic [1:0] bs);
    int   nb;
    logic p;
    nb = 5 + int'(bus.data_bits);
    p  = bus.par_odd ^ flip;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      drive_bit(d[i]);
      p = p ^ d[i];
    end
    if (bus.par_en) drive_bit(p);
    drive_bit(~bs[0]);
    if (bus.stop2) drive_bit(~bs[1]);
    uart_rx = 1'b1;
    cyc(3);
  endtask

  task automatic model_add(input logic [7:0] d, input bit flip, input logic [1:0] bs);
    ent_t e;
    int   nb;
    nb   = 5 + int'(bus.data_bits);
    e.d  = d & 8'((1 << nb) - 1);
    e.pe = bus.par_en ? flip : 1'b0;
    e.fe = bs[0] | (bus.stop2 & bs[1]);
    if (q.size() < DEPTH) q.push_back(e);
    else ovf_m = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input bit flip, input logic [1:0] bs);
    send_frame(d, flip, bs);
    model_add(d, flip, bs);
  endtask

  task automatic pop_check(input string tag);
    ent_t e;
    e = q.pop_front();
    chk({tag, "_valid"}, bus.rx_valid, 1'b1);
    chk({tag, "_data"},  bus.rx_data,  e.d);
    chk({tag, "_perr"},  bus.rx_perr,  e.pe);
    chk({tag, "_ferr"},  bus.rx_ferr,  e.fe);
    bus.rx_pop = 1'b1;
    @(negedge clk);
    bus.rx_pop = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) pop_check(tag);
    chk({tag, "_empty"}, bus.rx_count, 0);
    chk({tag, "_novalid"}, bus.rx_valid, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    uart_rx = 1'b1;
    bus.rec_en = 1'b0;
    bus.rx_pop = 1'b0;
    bus.ovf_clr = 1'b0;
    set_cfg(15, 3, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_count", bus.rx_count, 0);
    chk("rst_data",  bus.rx_data,  0);
    chk("rst_perr",  bus.rx_perr,  1'b0);
    chk("rst_ferr",  bus.rx_ferr,  1'b0);
    chk("rst_ovf",   bus.rx_ovf,   1'b0);
    @(negedge clk);
    rstn = 1'b1;
    bus.rec_en = 1'b1;
    cyc(4);

    // 8N1 latency: rx_valid rises on the 155th rising edge after the line falls
    fork
      send_frame(8'hA5, 1'b0, 2'b00);
      begin
        repeat (154) @(posedge clk);
        #1 chk("lat_before", bus.rx_valid, 1'b0);
        @(posedge clk);
        #1 chk("lat_at", bus.rx_valid, 1'b1);
      end
    join
    model_add(8'hA5, 1'b0, 2'b00);
    chk("a5_count", bus.rx_count, 1);
    drain("a5");

    // 7E2: good parity, flipped parity, low second stop bit
    set_cfg(7, 2, 1'b1, 1'b0, 1'b1);
    frame(8'h3C, 1'b0, 2'b00);
    frame(8'h3C, 1'b1, 2'b00);
    frame(8'h55, 1'b0, 2'b10);
    chk("7e2_count", bus.rx_count, 3);
    drain("7e2");

    // 4-cycle start glitch, then a real frame
    set_cfg(15, 3, 1'b0, 1'b0, 1'b0);
    uart_rx = 1'b0;
    cyc(4);
    uart_rx = 1'b1;
    cyc(30);
    chk("glitch_count", bus.rx_count, 0);
    frame(8'h81, 1'b0, 2'b00);
    drain("post_glitch");

    // overflow: 9 frames, no pops
    set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 2'b00);
    chk("ovf_count", bus.rx_count, DEPTH);
    chk("ovf_flag", bus.rx_ovf, ovf_m);
    drain("ovf");
    chk("ovf_kept", bus.rx_ovf, 1'b1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    ovf_m = 1'b0;
    chk("ovf_clr", bus.rx_ovf, 1'b0);

    // full FIFO, pop in the push cycle of the next frame
    for (int i = 0; i < DEPTH; i++) frame(8'h10 + 8'(i), 1'b0, 2'b00);
    set_cfg(15, 3, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h99, 1'b0, 2'b00);
      begin
        repeat (154) @(posedge clk);
        #1 bus.rx_pop = 1'b1;
        @(posedge clk);
        #1 bus.rx_pop = 1'b0;
      end
    join
    void'(q.pop_front());
    model_add(8'h99, 1'b0, 2'b00);
    chk("fullpop_count", bus.rx_count, DEPTH);
    chk("fullpop_ovf", bus.rx_ovf, 1'b0);
    drain("fullpop");

    // receiver disabled mid-DATA, then re-enabled
    set_cfg(7, 3, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'hF0, 1'b0, 2'b00);
      begin
        cyc(8 * 4);
        bus.rec_en = 1'b0;
      end
    join
    cyc(2);
    bus.rec_en = 1'b1;
    cyc(2);
    chk("dis_count", bus.rx_count, 0);
    frame(8'h5A, 1'b0, 2'b00);
    drain("reen");

    // randomized formats
    for (int i = 0; i < 10; i++) begin
      set_cfg(3 + $urandom_range(0, 9), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      frame(8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      chk("rnd_count", bus.rx_count, q.size());
      if (i % 3 == 2) drain("rnd");
    end
    drain("rnd_end");

    // async reset mid-frame with a full FIFO and overflow set
    set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    frame(8'hEE, 1'b0, 2'b01);
    for (int i = 0; i < DEPTH; i++) frame(8'hC0 + 8'(i), 1'b0, 2'b00);
    chk("pre_rst_ovf", bus.rx_ovf, 1'b1);
    chk("pre_rst_ferr", bus.rx_ferr, 1'b1);
    set_cfg(15, 3, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h77, 1'b0, 2'b00);
      begin
        cyc(40);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", bus.rx_valid, 1'b0);
        chk("arst_count", bus.rx_count, 0);
        chk("arst_data",  bus.rx_data,  0);
        chk("arst_ferr",  bus.rx_ferr,  1'b0);
        chk("arst_ovf",   bus.rx_ovf,   1'b0);
      end
    join
    q.delete();
    ovf_m = 1'b0;
    rstn = 1'b1;
    cyc(4);
    frame(8'h6B, 1'b0, 2'b00);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
